// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry and Gray/binary conversion helpers.
// Used by both the write-domain and read-domain pointer blocks.
package fifo_pkg;

    localparam int DEFAULT_ADDRESS_SIZE = 4;
    localparam int PTR_W                = DEFAULT_ADDRESS_SIZE + 1;

    // Helpers work on a zero-extended 32-bit container so one definition serves
    // any pointer width; callers pad on the way in and keep the low bits.
    localparam int MAX_PTR_W = 32;

    function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
        logic [MAX_PTR_W-1:0] b;
        b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_ptr_counter.sv
// Binary/Gray pointer register pair with increment enable.
// gnext is the Gray value the pointer takes on the coming edge.
module gray_ptr_counter
    import fifo_pkg::*;
#(
    parameter int WIDTH = PTR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] gnext
);

    logic [WIDTH-1:0]     bin_q;
    logic [WIDTH-1:0]     bin_d;
    logic [WIDTH-1:0]     gray_q;
    logic [WIDTH-1:0]     gray_d;
    logic [MAX_PTR_W-1:0] gnext_wide;
    logic                 unused_gnext_hi;

    always_comb begin
        // Natural wrap modulo 2**WIDTH drives the extra MSB toggle.
        bin_d           = bin_q + WIDTH'(inc);
        gnext_wide      = bin2gray(MAX_PTR_W'(bin_d));
        gray_d          = gnext_wide[WIDTH-1:0];
        unused_gnext_hi = ^(gnext_wide >> WIDTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    assign bin   = bin_q;
    assign gray  = gray_q;
    assign gnext = gray_d;

endmodule

// File: rtl/two_ff_synchronizer.sv
// Two-stage flop synchronizer for a multi-bit Gray-coded bus.
// Only one bit changes per source update, so per-bit capture is safe.
module two_ff_synchronizer #(
    parameter int SYNCHRONIZER_SIZE = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [SYNCHRONIZER_SIZE-1:0] d_async,
    output logic [SYNCHRONIZER_SIZE-1:0] q_sync
);

    logic [SYNCHRONIZER_SIZE-1:0] stage1_q;
    logic [SYNCHRONIZER_SIZE-1:0] stage2_q;
    logic [SYNCHRONIZER_SIZE-1:0] stage1_d;
    logic [SYNCHRONIZER_SIZE-1:0] stage2_d;

    always_comb begin
        stage1_d = d_async;
        stage2_d = stage1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= stage1_d;
            stage2_q <= stage2_d;
        end
    end

    assign q_sync = stage2_q;

endmodule

// File: rtl/w_clk_module.sv
// Write-domain pointer/flag logic of the async FIFO.
// Optional registered almost-full output under macro W_ALMOST_FULL_EN.
module w_clk_module
    import fifo_pkg::*;
#(
    parameter int ADDRESS_SIZE          = DEFAULT_ADDRESS_SIZE,
    parameter int MEMORY_DEPTH          = 16,
    parameter int ALMOST_FULL_THRESHOLD = 2
) (
    input  logic                  w_clk,
    input  logic                  wrst_n,
    input  logic                  w_en,
    input  logic [ADDRESS_SIZE:0] r_ptr,
    output logic [ADDRESS_SIZE:0] w_ptr,
    output logic [ADDRESS_SIZE-1:0] w_addr,
    output logic                  w_mem_en,
    output logic                  w_full
`ifdef W_ALMOST_FULL_EN
    ,
    output logic                  w_almost_full
`endif
);

    localparam int PW = ADDRESS_SIZE + 1;

    generate
        if (ADDRESS_SIZE < 2 || MEMORY_DEPTH != (1 << ADDRESS_SIZE) ||
            ALMOST_FULL_THRESHOLD < 0 || ALMOST_FULL_THRESHOLD > MEMORY_DEPTH) begin : g_bad_cfg
            $error("w_clk_module: inconsistent ADDRESS_SIZE/MEMORY_DEPTH/ALMOST_FULL_THRESHOLD");
        end
    endgenerate

    logic          w_accept;
    logic [PW-1:0] w_bin;
    logic [PW-1:0] w_gnext;
    logic [PW-1:0] wq2_rptr;
    logic [PW-1:0] full_match;
    logic          w_full_q;
    logic          w_full_d;

    assign w_accept = w_en & ~w_full_q;

    gray_ptr_counter #(
        .WIDTH (PW)
    ) u_wptr (
        .clk   (w_clk),
        .rst_n (wrst_n),
        .inc   (w_accept),
        .bin   (w_bin),
        .gray  (w_ptr),
        .gnext (w_gnext)
    );

    two_ff_synchronizer #(
        .SYNCHRONIZER_SIZE (PW)
    ) u_rptr_sync (
        .clk     (w_clk),
        .rst_n   (wrst_n),
        .d_async (r_ptr),
        .q_sync  (wq2_rptr)
    );

    // Full when the next write pointer has lapped the read pointer exactly once.
    always_comb begin
        full_match = {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]};
        w_full_d   = (w_gnext == full_match);
    end

    always_ff @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            w_full_q <= 1'b0;
        end else begin
            w_full_q <= w_full_d;
        end
    end

    assign w_full   = w_full_q;
    assign w_addr   = w_bin[ADDRESS_SIZE-1:0];
    // Held low while reset is asserted so no stray memory write lands at address 0.
    assign w_mem_en = w_accept & wrst_n;

`ifdef W_ALMOST_FULL_EN
    localparam logic [PW-1:0] AF_LEVEL = PW'(MEMORY_DEPTH - ALMOST_FULL_THRESHOLD);

    logic [PW-1:0]        w_bnext;
    logic [MAX_PTR_W-1:0] rbin_wide;
    logic [PW-1:0]        wq2_rbin;
    logic [PW-1:0]        occupancy;
    logic                 unused_rbin_hi;
    logic                 w_almost_full_q;
    logic                 w_almost_full_d;

    always_comb begin
        w_bnext         = w_bin + PW'(w_accept);
        rbin_wide       = gray2bin(MAX_PTR_W'(wq2_rptr));
        wq2_rbin        = rbin_wide[PW-1:0];
        unused_rbin_hi  = ^(rbin_wide >> PW);
        occupancy       = w_bnext - wq2_rbin;
        w_almost_full_d = (occupancy >= AF_LEVEL);
    end

    always_ff @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            w_almost_full_q <= 1'b0;
        end else begin
            w_almost_full_q <= w_almost_full_d;
        end
    end

    assign w_almost_full = w_almost_full_q;
`endif

endmodule
